led_control_module: RTL and testbench
=====================================

Name: led_control_module

Overview:
- UART command receiver/decoder for the LED-matrix display pipeline.
- Deserialises an 8N1 byte stream on uart_rx and decodes single-byte ASCII opcodes.
- Drives colour-plane enables and the brightness mask.
- Writes frame-buffer row data into the external display RAM through a simple write port.
- Sits between the host serial link and the display RAM/scan logic.

Parameters:
- UART_CLK_TICKS_PER_BIT, 7'd65: clk_in cycles per UART bit; 16 MHz / 65 ≈ 246 kbaud.
- CMD_TIMEOUT_BITS, 64: idle bit-times before a half-received command is abandoned (used only with CMD_TIMEOUT_EN).

Ports:
- clk_in  in  1  system clock, 16 MHz nominal; the only clock.
- reset  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial data in, idle high.
- rx_running  out  1  high while a UART frame is being received (start bit through stop bit).
- rgb_enable  out  3  colour-plane enables {blue, green, red}.
- brightness_enable  out  6  brightness bit-plane mask.
- ram_data_out  out  8  byte to write to display RAM.
- ram_address  out  12  write address {row[4:0], byte_index[6:0]}.
- ram_write_enable  out  1  one-cycle write strobe.
- ram_clk_enable  out  1  high while a row load ('L') is in progress.
- ram_reset  out  1  active-high RAM reset.
- cmd_line_state2  out  2  command FSM state: 0 IDLE, 1 ROW, 2 DATA, 3 BRIGHT.
- num_commands_processed  out  8  count of completed commands, wraps 255->0.

Behaviour:
Reset values:
- Outputs: rgb_enable=3'b111, brightness_enable=6'b111111, ram_data_out=0, ram_address=0, ram_write_enable=0, ram_clk_enable=0, cmd_line_state2=0, num_commands_processed=0, rx_running=0.
- ram_reset is high while reset is low and for exactly one clk_in cycle after release.

UART receiver:
- uart_rx passes through a 2-flop synchroniser.
- A start bit is a synchronised falling edge while idle.
- Start is re-checked at half a bit-time; if high, the frame is aborted (glitch) and rx_running drops.
- Data bits are sampled at bit centres, LSB first.
- The stop bit is sampled at its centre. If high, a one-cycle byte_valid pulse is generated; if low, the byte is discarded (framing error, no FSM effect).
- rx_running falls on the cycle of the stop-bit sample.

Command FSM (acts on byte_valid only):
- IDLE:
  - 'R'/'G'/'B' set rgb_enable bit 0/1/2; 'r'/'g'/'b' clear it. Each completes immediately.
  - 'T' goes to BRIGHT.
  - 'L' goes to ROW and asserts ram_clk_enable.
  - Any other byte (including space) is ignored: no state change, no count.
- BRIGHT: next byte sets brightness_enable=byte[5:0], completes, goes to IDLE.
- ROW: next byte latches row=byte[4:0], clears byte_index to 0, goes to DATA.
- DATA, per byte:
  - ram_data_out=byte and ram_address={row,byte_index}; ram_write_enable high for exactly one cycle, in the cycle after byte_valid, with address and data stable in that cycle.
  - Then byte_index increments.
  - After the 128th byte (index 127): command completes, ram_clk_enable drops, goes to IDLE.
- Opcode bytes received in ROW/DATA/BRIGHT are treated as payload, not commands.

Completion:
- num_commands_processed increments by 1 in the cycle a command completes.
- Modulo-256 wrap.

Reset mid-operation:
- Asynchronous return to reset values.
- A partial row load leaves RAM contents already written untouched.

Optional Feature:
- Macro CMD_TIMEOUT_EN.
- Defined: in ROW, DATA or BRIGHT, a counter runs in bit-times while no byte arrives. After CMD_TIMEOUT_BITS bit-times the FSM returns to IDLE, ram_clk_enable drops, and num_commands_processed is unchanged. The counter clears on every byte_valid.
- Undefined: no timeout; the FSM waits indefinitely for payload bytes.

Test Plan:
- Reset release: check every output against its reset value. Check ram_reset is high through reset plus 1 cycle.
- Send 'b','r','R' (650 cycles per byte at 65 ticks):
  - rgb_enable steps 111 -> 011 -> 010 -> 011.
  - num_commands_processed = 3.
- Send ' ': no change to any output; count stays 3.
- Send 'L','-', then 128 ASCII digit bytes:
  - Row = 0x2D[4:0] = 13.
  - Exactly 128 ram_write_enable pulses, addresses 0x680..0x6FF, data equal to the bytes sent.
  - ram_clk_enable high from 'L' until the last write.
  - Count increments once, to 4.
- Send 'T',0xFF: brightness_enable = 6'b111111; cmd_line_state2 reads 3 between the two bytes.
- Frame with stop bit low: no byte accepted and no state change. Frame with a 10-cycle start glitch: no byte and rx_running returns low.

Source files
------------

// File: rtl/led_control_module.sv
// UART opcode receiver driving LED colour planes, brightness mask and display-RAM row writes.
// Optional build macro CMD_TIMEOUT_EN abandons a half-received command after CMD_TIMEOUT_BITS idle bit-times.
module led_control_module #(
  parameter logic [6:0] UART_CLK_TICKS_PER_BIT = 7'd65,
  parameter int         CMD_TIMEOUT_BITS       = 64
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        rx_running,
  output logic [2:0]  rgb_enable,
  output logic [5:0]  brightness_enable,
  output logic [7:0]  ram_data_out,
  output logic [11:0] ram_address,
  output logic        ram_write_enable,
  output logic        ram_clk_enable,
  output logic        ram_reset,
  output logic [1:0]  cmd_line_state2,
  output logic [7:0]  num_commands_processed
);

  localparam logic [6:0] HALF_BIT = UART_CLK_TICKS_PER_BIT >> 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {CMD_IDLE = 2'd0, CMD_ROW = 2'd1, CMD_DATA = 2'd2, CMD_BRIGHT = 2'd3} cmd_state_t;

  logic       rx_meta, rx_sync, rx_prev, ram_reset_pre;
  rx_state_t  rx_state, rx_state_next;
  logic [6:0] rx_cnt, rx_cnt_next;
  logic [2:0] rx_bit, rx_bit_next;
  logic [7:0] rx_shift, rx_shift_next;
  logic       byte_valid, byte_valid_next;

  cmd_state_t cmd_state, cmd_next;
  logic [2:0]  rgb_next;
  logic [5:0]  bright_next;
  logic [4:0]  row, row_next;
  logic [6:0]  byte_index, idx_next;
  logic [7:0]  data_next;
  logic [11:0] addr_next;
  logic        we_next, clk_en_next, done, timeout;

  // Input synchroniser plus one delay stage for falling-edge detection; RAM reset stretch
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_prev       <= 1'b1;
      ram_reset_pre <= 1'b1;
      ram_reset     <= 1'b1;
    end else begin
      rx_meta       <= uart_rx;
      rx_sync       <= rx_meta;
      rx_prev       <= rx_sync;
      ram_reset_pre <= 1'b0;
      ram_reset     <= ram_reset_pre;
    end
  end

  // UART receiver state register
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= 7'd0;
      rx_bit     <= 3'd0;
      rx_shift   <= 8'd0;
      byte_valid <= 1'b0;
      rx_running <= 1'b0;
    end else begin
      rx_state   <= rx_state_next;
      rx_cnt     <= rx_cnt_next;
      rx_bit     <= rx_bit_next;
      rx_shift   <= rx_shift_next;
      byte_valid <= byte_valid_next;
      rx_running <= (rx_state_next != RX_IDLE);
    end
  end

  // UART receiver next state: half-bit start recheck, then centre sampling of data and stop
  always_comb begin
    rx_state_next   = rx_state;
    rx_cnt_next     = rx_cnt + 7'd1;
    rx_bit_next     = rx_bit;
    rx_shift_next   = rx_shift;
    byte_valid_next = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_next = 7'd0;
        if (rx_prev && !rx_sync) rx_state_next = RX_START;
        else                     rx_state_next = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt == HALF_BIT - 7'd1) begin
          rx_cnt_next = 7'd0;
          rx_bit_next = 3'd0;
          if (rx_sync) rx_state_next = RX_IDLE;
          else         rx_state_next = RX_DATA;
        end else begin
          rx_state_next = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt == UART_CLK_TICKS_PER_BIT - 7'd1) begin
          rx_cnt_next   = 7'd0;
          rx_shift_next = {rx_sync, rx_shift[7:1]};
          rx_bit_next   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_next = RX_STOP;
          else                rx_state_next = RX_DATA;
        end else begin
          rx_state_next = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_cnt == UART_CLK_TICKS_PER_BIT - 7'd1) begin
          rx_state_next   = RX_IDLE;
          byte_valid_next = rx_sync;
        end else begin
          rx_state_next = RX_STOP;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

`ifdef CMD_TIMEOUT_EN
  logic [6:0]  to_tick;
  logic [15:0] to_bits;

  // Idle bit-time counter while a command waits for payload
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      to_tick <= 7'd0;
      to_bits <= 16'd0;
    end else if (byte_valid || cmd_state == CMD_IDLE) begin
      to_tick <= 7'd0;
      to_bits <= 16'd0;
    end else if (to_tick == UART_CLK_TICKS_PER_BIT - 7'd1) begin
      to_tick <= 7'd0;
      to_bits <= to_bits + 16'd1;
    end else begin
      to_tick <= to_tick + 7'd1;
    end
  end

  assign timeout = (to_bits == 16'(CMD_TIMEOUT_BITS));
`else
  assign timeout = 1'b0;
`endif

  // Command FSM register and its registered outputs
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cmd_state              <= CMD_IDLE;
      rgb_enable             <= 3'b111;
      brightness_enable      <= 6'b111111;
      row                    <= 5'd0;
      byte_index             <= 7'd0;
      ram_data_out           <= 8'd0;
      ram_address            <= 12'd0;
      ram_write_enable       <= 1'b0;
      ram_clk_enable         <= 1'b0;
      num_commands_processed <= 8'd0;
    end else begin
      cmd_state              <= cmd_next;
      rgb_enable             <= rgb_next;
      brightness_enable      <= bright_next;
      row                    <= row_next;
      byte_index             <= idx_next;
      ram_data_out           <= data_next;
      ram_address            <= addr_next;
      ram_write_enable       <= we_next;
      ram_clk_enable         <= clk_en_next;
      num_commands_processed <= num_commands_processed + {7'd0, done};
    end
  end

  assign cmd_line_state2 = cmd_state;

  // Command decode; bytes after an opcode are payload regardless of value
  always_comb begin
    cmd_next    = cmd_state;
    rgb_next    = rgb_enable;
    bright_next = brightness_enable;
    row_next    = row;
    idx_next    = byte_index;
    data_next   = ram_data_out;
    addr_next   = ram_address;
    we_next     = 1'b0;
    done        = 1'b0;
    if (byte_valid) begin
      case (cmd_state)
        CMD_IDLE: begin
          case (rx_shift)
            8'h52:   begin rgb_next[0] = 1'b1; done = 1'b1; end
            8'h47:   begin rgb_next[1] = 1'b1; done = 1'b1; end
            8'h42:   begin rgb_next[2] = 1'b1; done = 1'b1; end
            8'h72:   begin rgb_next[0] = 1'b0; done = 1'b1; end
            8'h67:   begin rgb_next[1] = 1'b0; done = 1'b1; end
            8'h62:   begin rgb_next[2] = 1'b0; done = 1'b1; end
            8'h54:   cmd_next = CMD_BRIGHT;
            8'h4C:   cmd_next = CMD_ROW;
            default: cmd_next = CMD_IDLE;
          endcase
        end
        CMD_BRIGHT: begin
          bright_next = rx_shift[5:0];
          done        = 1'b1;
          cmd_next    = CMD_IDLE;
        end
        CMD_ROW: begin
          row_next = rx_shift[4:0];
          idx_next = 7'd0;
          cmd_next = CMD_DATA;
        end
        CMD_DATA: begin
          we_next   = 1'b1;
          data_next = rx_shift;
          addr_next = {row, byte_index};
          idx_next  = byte_index + 7'd1;
          if (byte_index == 7'd127) begin
            done     = 1'b1;
            cmd_next = CMD_IDLE;
          end else begin
            cmd_next = CMD_DATA;
          end
        end
        default: cmd_next = CMD_IDLE;
      endcase
    end else if (timeout && cmd_state != CMD_IDLE) begin
      cmd_next = CMD_IDLE;
    end else begin
      cmd_next = cmd_state;
    end
    // Keep the RAM clock enabled through the final write strobe
    clk_en_next = (cmd_next == CMD_ROW) || (cmd_next == CMD_DATA) ||
                  (cmd_state == CMD_DATA && byte_valid);
  end

endmodule

// File: tb/tb_led_control_module.sv
// Directed bench for led_control_module: opcodes, row load, brightness, framing error and start glitch.
module tb_led_control_module;
  logic        clk_in, reset, uart_rx;
  logic        rx_running, ram_write_enable, ram_clk_enable, ram_reset;
  logic [2:0]  rgb_enable;
  logic [5:0]  brightness_enable;
  logic [7:0]  ram_data_out, num_commands_processed;
  logic [11:0] ram_address;
  logic [1:0]  cmd_line_state2;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic        wr_clk_q[$];

  led_control_module dut (
    .clk_in(clk_in), .reset(reset), .uart_rx(uart_rx), .rx_running(rx_running),
    .rgb_enable(rgb_enable), .brightness_enable(brightness_enable),
    .ram_data_out(ram_data_out), .ram_address(ram_address),
    .ram_write_enable(ram_write_enable), .ram_clk_enable(ram_clk_enable),
    .ram_reset(ram_reset), .cmd_line_state2(cmd_line_state2),
    .num_commands_processed(num_commands_processed)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (ram_write_enable) begin
      wr_addr_q.push_back(ram_address);
      wr_data_q.push_back(ram_data_out);
      wr_clk_q.push_back(ram_clk_enable);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(65);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(65);
    end
    uart_rx = stop_bit;
    tick(65);
    uart_rx = 1'b1;
  endtask

  task automatic check_status(input string name, input logic [2:0] rgb, input logic [5:0] br,
                              input logic [1:0] st, input logic [7:0] cnt);
    vectors++;
    if ({rgb_enable, brightness_enable, cmd_line_state2, num_commands_processed, rx_running} !==
        {rgb, br, st, cnt, 1'b0}) begin
      miscompares++;
      $display("FAIL %s: got rgb=%b br=%b st=%0d cnt=%0d rxr=%b, expected rgb=%b br=%b st=%0d cnt=%0d rxr=0",
               name, rgb_enable, brightness_enable, cmd_line_state2, num_commands_processed,
               rx_running, rgb, br, st, cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    uart_rx = 1'b1;
    tick(3);
    vectors++;
    if ({rx_running, rgb_enable, brightness_enable, ram_data_out, ram_address, ram_write_enable,
         ram_clk_enable, cmd_line_state2, num_commands_processed} !==
        {1'b0, 3'b111, 6'b111111, 8'd0, 12'd0, 1'b0, 1'b0, 2'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got rgb=%b br=%b d=%h a=%h we=%b ce=%b st=%0d cnt=%0d rxr=%b",
               rgb_enable, brightness_enable, ram_data_out, ram_address, ram_write_enable,
               ram_clk_enable, cmd_line_state2, num_commands_processed, rx_running);
    end
    vectors++;
    if (ram_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL ram_reset_during: got %b expected 1", ram_reset);
    end
    reset = 1'b1;
    tick(1);
    vectors++;
    if (ram_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL ram_reset_stretch: got %b expected 1", ram_reset);
    end
    tick(1);
    vectors++;
    if (ram_reset !== 1'b0) begin
      miscompares++;
      $display("FAIL ram_reset_release: got %b expected 0", ram_reset);
    end
    check_status("reset_status", 3'b111, 6'b111111, 2'd0, 8'd0);
  endtask

  task automatic test_rgb();
    send_frame(8'h62, 1'b1);
    check_status("rgb_b", 3'b011, 6'b111111, 2'd0, 8'd1);
    send_frame(8'h72, 1'b1);
    check_status("rgb_r", 3'b010, 6'b111111, 2'd0, 8'd2);
    send_frame(8'h52, 1'b1);
    check_status("rgb_R", 3'b011, 6'b111111, 2'd0, 8'd3);
  endtask

  task automatic test_ignored();
    send_frame(8'h20, 1'b1);
    check_status("space_ignored", 3'b011, 6'b111111, 2'd0, 8'd3);
    vectors++;
    if ({ram_clk_enable, ram_write_enable, ram_address, ram_data_out} !== {1'b0, 1'b0, 12'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL space_ram: got ce=%b we=%b a=%h d=%h expected all zero",
               ram_clk_enable, ram_write_enable, ram_address, ram_data_out);
    end
  endtask

  task automatic test_row_load();
    int bad;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_clk_q.delete();
    send_frame(8'h4C, 1'b1);
    vectors++;
    if ({cmd_line_state2, ram_clk_enable} !== {2'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL row_after_L: got st=%0d ce=%b expected st=1 ce=1", cmd_line_state2, ram_clk_enable);
    end
    send_frame(8'h2D, 1'b1);
    vectors++;
    if ({cmd_line_state2, ram_clk_enable, num_commands_processed} !== {2'd2, 1'b1, 8'd3}) begin
      miscompares++;
      $display("FAIL row_after_row: got st=%0d ce=%b cnt=%0d expected st=2 ce=1 cnt=3",
               cmd_line_state2, ram_clk_enable, num_commands_processed);
    end
    for (int i = 0; i < 128; i++) begin
      send_frame(8'h30 + 8'(i % 10), 1'b1);
    end
    vectors++;
    if (wr_addr_q.size() !== 128) begin
      miscompares++;
      $display("FAIL row_write_count: got %0d expected 128", wr_addr_q.size());
    end
    bad = -1;
    for (int i = 0; i < wr_addr_q.size() && i < 128; i++) begin
      if (bad < 0 && (wr_addr_q[i] !== 12'h680 + 12'(i) || wr_data_q[i] !== 8'h30 + 8'(i % 10) ||
                      wr_clk_q[i] !== 1'b1)) bad = i;
    end
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL row_write_content: write %0d got a=%h d=%h ce=%b expected a=%h d=%h ce=1",
               bad, wr_addr_q[bad], wr_data_q[bad], wr_clk_q[bad], 12'h680 + 12'(bad),
               8'h30 + 8'(bad % 10));
    end
    vectors++;
    if ({ram_clk_enable, ram_write_enable} !== 2'b00) begin
      miscompares++;
      $display("FAIL row_end_ram: got ce=%b we=%b expected 0 0", ram_clk_enable, ram_write_enable);
    end
    check_status("row_done", 3'b011, 6'b111111, 2'd0, 8'd4);
  endtask

  task automatic test_brightness();
    send_frame(8'h54, 1'b1);
    check_status("bright_wait", 3'b011, 6'b111111, 2'd3, 8'd4);
    send_frame(8'h15, 1'b1);
    check_status("bright_15", 3'b011, 6'b010101, 2'd0, 8'd5);
    send_frame(8'h54, 1'b1);
    check_status("bright_wait2", 3'b011, 6'b010101, 2'd3, 8'd5);
    send_frame(8'hFF, 1'b1);
    check_status("bright_ff", 3'b011, 6'b111111, 2'd0, 8'd6);
  endtask

  task automatic test_framing_error();
    send_frame(8'h72, 1'b0);
    tick(100);
    check_status("framing_error", 3'b011, 6'b111111, 2'd0, 8'd6);
  endtask

  task automatic test_glitch();
    uart_rx = 1'b0;
    tick(8);
    vectors++;
    if (rx_running !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_start: got rx_running=%b expected 1", rx_running);
    end
    tick(2);
    uart_rx = 1'b1;
    tick(60);
    check_status("glitch_abort", 3'b011, 6'b111111, 2'd0, 8'd6);
    send_frame(8'h67, 1'b1);
    check_status("after_glitch_g", 3'b001, 6'b111111, 2'd0, 8'd7);
  endtask

  initial begin
    test_reset();
    test_rgb();
    test_ignored();
    test_row_load();
    test_brightness();
    test_framing_error();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
